lsu_split: RTL and testbench
============================

# lsu_split

Load/store unit that acts as the initiator toward the word-organised data memory: it accepts one RV32 load or store from the MEM stage, drives the memory's write-enable, byte-enable, word address and write data, and returns sign/zero-extended load data. Accesses that cross a 32-bit word boundary are split into two back-to-back word accesses and reassembled. It sits between the pipeline's MEM stage and the data memory.

## Interface
- No parameters; data and address width fixed at 32.
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32 funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU (loads); 000/001/010 (stores).
- req_addr  in  32  byte address, any alignment.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  unsupported funct3; qualified by resp_valid.
- mem_we  out  1  write enable to data memory.
- mem_be  out  4  byte enables; never 0000 while mem_we=1.
- mem_addr  out  32  word-aligned address (bits [1:0] = 00).
- mem_wd  out  32  lane-aligned write data.
- mem_rd  in  32  read word; valid the cycle after its address is driven (memory registers it).

## Operation
- Handshake: request accepted on the edge where req_valid && req_ready; all request fields latched then; inputs ignored until next IDLE.
- Size n = 1/2/4 bytes from funct3[1:0]; offset o = addr[1:0]; 8-bit mask m = ((1<<n)-1) << o; be0 = m[3:0], be1 = m[7:4]; split iff be1 != 0.
- Word 0 address = {addr[31:2],2'b00}; word 1 = word 0 + 4, modulo 2^32 (0xFFFFFFFC wraps to 0x00000000).
- Store data: 64-bit value ({32'b0, wdata masked to n bytes}) << 8*o; low half to word 0, high half to word 1.
- Load data: {rd1, rd0} >> 8*o, take n bytes, sign-extend (B/H) or zero-extend (BU/HU/W).
- States:
  - IDLE: req_ready=1, mem_we=0, mem_be=0. Accept: legal funct3 -> ACC0; illegal (011, 110, 111; or funct3[2]=1 with store) -> DONE with err flag, no memory access.
  - ACC0: drive word 0, be0, mem_we=req_store. Next -> ACC1 if split, else DONE.
  - ACC1: drive word 1, be1, mem_we=req_store; capture mem_rd (word 0 data) into buffer. Next -> DONE.
  - DONE: mem_we=0, mem_be=0; capture last mem_rd; resp_valid=1 with assembled resp_rdata; -> IDLE.
- Loads drive mem_be with the mask too (memory ignores it when mem_we=0).
- Reset values: state IDLE, req_ready=1 once out of reset, resp_valid=0, resp_rdata=0, resp_err=0, mem_we=0, mem_be=0, mem_addr=0, mem_wd=0, buffers 0.
- Reset mid-split: any half already written stays written; no response is produced.

## Timing
- mem_* outputs are decoded from registered state and latched request only; no combinational path from req_* to mem_*.
- Aligned/non-split: accept at edge E; ACC0 in cycle E+1; resp_valid in cycle E+2; req_ready again in E+3.
- Split: resp_valid in cycle E+3.
- Illegal funct3: resp_valid, resp_err=1 in cycle E+1.
- Back-to-back: throughput one access per 3 cycles (aligned), 4 cycles (split).

## Structure
- Package lsu_pkg: funct3 localparams (LB, LH, LW, LBU, LHU, SB, SH, SW), state enum (IDLE, ACC0, ACC1, DONE), size-decode function.
- One combinational sub-module lsu_align: mask, split flag, 64-bit store shift, load extract/extend. The FSM and buffers live in lsu_split.

## Test plan
- LW addr 0x10, mem word 0x10 = 0x8899AABB -> one access be=1111, resp_rdata 0x8899AABB at E+2.
- LB addr 0x13, word 0x10 = 0x80112233 -> be0=1000, resp_rdata 0xFFFFFF80; LBU -> 0x00000080.
- SW 0xDEADBEEF addr 0x0E -> cycle E+1: addr 0x0C, be 1100, wd 0xBEEF0000; E+2: addr 0x10, be 0011, wd 0x0000DEAD; resp_valid E+3.
- LH addr 0xFFFFFFFF -> second access at mem_addr 0x00000000 be 0001; result {byte0 of word 0, byte3 of word 0xFFFFFFFC}, sign-extended.
- req_funct3=011 load -> no mem_we/mem_be activity, resp_valid+resp_err at E+1, resp_rdata 0.
- rst_n low during ACC1 of split store -> all outputs go to reset values immediately, first-half bytes present in memory, no resp_valid, next request served normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit:
//   - RV32 load/store funct3 encodings
//   - FSM state encodings
//   - size decode and legality helpers
package lsu_pkg;

  localparam int unsigned XLEN = 32;

  // Load funct3 encodings
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store funct3 encodings
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC0 = 2'd1;
  localparam logic [1:0] ST_ACC1 = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  // Size decode: unshifted byte mask (1, 2 or 4 bytes) from funct3[1:0]
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    logic [3:0] m;
    case (f3[1:0])
      2'b00:   m = 4'b0001;
      2'b01:   m = 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  // Legal funct3 for the given direction
  function automatic logic funct3_legal(input logic store, input logic [2:0] f3);
    logic ok;
    if (store) begin
      ok = (f3 == SB) || (f3 == SH) || (f3 == SW);
    end else begin
      ok = (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Purely combinational lane alignment for the LSU.
//   funct3  : access size and signedness
//   offset  : byte offset within the first word
//   wdata   : right-justified store data
//   rd_lo   : first word read back
//   rd_hi   : low three bytes of the second word (byte 3 can never be needed)
//   be0/be1 : byte enables for the first/second word
//   split   : access spills into the second word
//   st_lo/st_hi : lane-aligned store data for the first/second word
//   ld_data : extracted and extended load result
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rd_lo,
  input  logic [23:0]     rd_hi,
  output logic [3:0]      be0,
  output logic [3:0]      be1,
  output logic            split,
  output logic [XLEN-1:0] st_lo,
  output logic [XLEN-1:0] st_hi,
  output logic [XLEN-1:0] ld_data
);

  logic [3:0]  base;
  logic [7:0]  mask;
  logic [31:0] wmask;
  logic [63:0] st64;
  logic [55:0] rd56;
  logic [31:0] win;

  // Byte mask, store shift, load window select and extension
  always_comb begin
    base  = size_mask(funct3);
    mask  = {4'b0000, base} << offset;
    be0   = mask[3:0];
    be1   = mask[7:4];
    split = |mask[7:4];

    wmask = {{8{base[3]}}, {8{base[2]}}, {8{base[1]}}, {8{base[0]}}};
    st64  = {32'h0, wdata & wmask} << {offset, 3'b000};
    st_lo = st64[31:0];
    st_hi = st64[63:32];

    rd56 = {rd_hi, rd_lo};
    case (offset)
      2'd0:    win = rd56[31:0];
      2'd1:    win = rd56[39:8];
      2'd2:    win = rd56[47:16];
      default: win = rd56[55:24];
    endcase

    case (funct3[1:0])
      2'b00:   ld_data = funct3[2] ? {24'h0, win[7:0]}  : {{24{win[7]}}, win[7:0]};
      2'b01:   ld_data = funct3[2] ? {16'h0, win[15:0]} : {{16{win[15]}}, win[15:0]};
      default: ld_data = win;
    endcase
  end

endmodule

// File: rtl/lsu_split.sv
// Load/store unit toward a word-organised data memory. Accepts one RV32
// load/store, splits word-crossing accesses into two word accesses and
// reassembles the load result.
//   req_*  : request handshake from the MEM stage (accepted in IDLE only)
//   resp_* : one-cycle completion pulse with extended load data / error
//   mem_*  : word-aligned memory port; mem_rd arrives the cycle after its address
module lsu_split
  import lsu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic            mem_we,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wd,
  input  logic [XLEN-1:0] mem_rd
);

  logic [1:0]      state_q,  state_d;
  logic            store_q,  store_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] addr_q,   addr_d;
  logic [XLEN-1:0] wdata_q,  wdata_d;
  logic            err_q,    err_d;
  logic [XLEN-1:0] buf0_q,   buf0_d;

  logic [3:0]      be0, be1;
  logic            split;
  logic [XLEN-1:0] st_lo, st_hi, ld_data;
  logic [XLEN-1:0] rd_lo;
  logic [23:0]     rd_hi;
  logic [XLEN-1:0] word0_addr;

  // First word comes from the buffer only when a second access followed it
  assign rd_lo      = split ? buf0_q : mem_rd;
  assign rd_hi      = split ? mem_rd[23:0] : 24'h0;
  assign word0_addr = {addr_q[31:2], 2'b00};

  lsu_align u_align (
    .funct3  (funct3_q),
    .offset  (addr_q[1:0]),
    .wdata   (wdata_q),
    .rd_lo   (rd_lo),
    .rd_hi   (rd_hi),
    .be0     (be0),
    .be1     (be1),
    .split   (split),
    .st_lo   (st_lo),
    .st_hi   (st_hi),
    .ld_data (ld_data)
  );

  // State and latched request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      err_q    <= 1'b0;
      buf0_q   <= '0;
    end else begin
      state_q  <= state_d;
      store_q  <= store_d;
      funct3_q <= funct3_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      err_q    <= err_d;
      buf0_q   <= buf0_d;
    end
  end

  // Next state, request capture and first-word buffering
  always_comb begin
    state_d  = state_q;
    store_d  = store_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    err_d    = err_q;
    buf0_d   = buf0_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          store_d  = req_store;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          err_d    = !funct3_legal(req_store, req_funct3);
          state_d  = funct3_legal(req_store, req_funct3) ? ST_ACC0 : ST_DONE;
        end
      end
      ST_ACC0: state_d = split ? ST_ACC1 : ST_DONE;
      ST_ACC1: begin
        buf0_d  = mem_rd;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode from registered state and latched request only
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    mem_we     = 1'b0;
    mem_be     = 4'b0000;
    mem_addr   = '0;
    mem_wd     = '0;
    case (state_q)
      ST_IDLE: req_ready = 1'b1;
      ST_ACC0: begin
        mem_we   = store_q;
        mem_be   = be0;
        mem_addr = word0_addr;
        mem_wd   = store_q ? st_lo : '0;
      end
      ST_ACC1: begin
        mem_we   = store_q;
        mem_be   = be1;
        mem_addr = word0_addr + 32'd4;
        mem_wd   = store_q ? st_hi : '0;
      end
      default: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || store_q) ? '0 : ld_data;
      end
    endcase
  end

endmodule

// File: tb/tb_lsu_split.sv
// Directed self-checking bench for lsu_split with a registered-read word memory.
module tb_lsu_split;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_data;

  int compared;
  int mismatched;

  lsu_split dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wd     (mem_wd),
    .mem_rd     (mem_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word memory: byte-enabled write, registered read, backdoor preload port
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_idx] <= pl_data;
    end else if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wd[8*b +: 8];
      end
    end
    mem_rd <= mem[mem_addr[7:2]];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    pl_en   = 1'b1;
    pl_idx  = idx;
    pl_data = data;
    tick();
    pl_en   = 1'b0;
  endtask

  // Present a request for one edge; returns in cycle E+1
  task automatic issue(input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    req_store  = st;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = 1'b1;
    tick();
    req_valid  = 1'b0;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_store  = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    pl_en      = 1'b0;
    pl_idx     = 6'd0;
    pl_data    = 32'h0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Reset state
    tick();
    chk("rst resp_valid", 32'(resp_valid), 32'd0);
    chk("rst resp_rdata", resp_rdata, 32'h0);
    chk("rst resp_err",   32'(resp_err), 32'd0);
    chk("rst mem_we",     32'(mem_we), 32'd0);
    chk("rst mem_be",     32'(mem_be), 32'd0);
    chk("rst mem_addr",   mem_addr, 32'h0);
    chk("rst mem_wd",     mem_wd, 32'h0);
    rst_n = 1'b1;
    tick();
    chk("ready after rst", 32'(req_ready), 32'd1);

    // LW aligned
    poke(6'd4, 32'h8899AABB);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw E1 addr",  mem_addr, 32'h10);
    chk("lw E1 be",    32'(mem_be), 32'hF);
    chk("lw E1 we",    32'(mem_we), 32'd0);
    chk("lw E1 valid", 32'(resp_valid), 32'd0);
    chk("lw E1 ready", 32'(req_ready), 32'd0);
    tick();
    chk("lw E2 valid", 32'(resp_valid), 32'd1);
    chk("lw E2 rdata", resp_rdata, 32'h8899AABB);
    chk("lw E2 err",   32'(resp_err), 32'd0);
    tick();
    chk("lw E3 valid", 32'(resp_valid), 32'd0);
    chk("lw E3 ready", 32'(req_ready), 32'd1);

    // LB / LBU at top byte
    poke(6'd4, 32'h80112233);
    issue(1'b0, 3'b000, 32'h13, 32'h0);
    chk("lb E1 be",   32'(mem_be), 32'h8);
    chk("lb E1 addr", mem_addr, 32'h10);
    tick();
    chk("lb rdata",   resp_rdata, 32'hFFFFFF80);
    tick();
    issue(1'b0, 3'b100, 32'h13, 32'h0);
    tick();
    chk("lbu rdata",  resp_rdata, 32'h00000080);
    tick();

    // SH non-split: wdata upper bits masked off
    issue(1'b1, 3'b001, 32'h11, 32'hFFFF1234);
    chk("sh E1 be", 32'(mem_be), 32'h6);
    chk("sh E1 wd", mem_wd, 32'h00123400);
    chk("sh E1 we", 32'(mem_we), 32'd1);
    tick();
    chk("sh E2 valid", 32'(resp_valid), 32'd1);
    tick();

    // SW split across 0x0C/0x10
    poke(6'd3, 32'h11223344);
    poke(6'd4, 32'h55667788);
    issue(1'b1, 3'b010, 32'h0E, 32'hDEADBEEF);
    chk("sw E1 addr", mem_addr, 32'h0C);
    chk("sw E1 be",   32'(mem_be), 32'hC);
    chk("sw E1 wd",   mem_wd, 32'hBEEF0000);
    chk("sw E1 we",   32'(mem_we), 32'd1);
    tick();
    chk("sw E2 addr",  mem_addr, 32'h10);
    chk("sw E2 be",    32'(mem_be), 32'h3);
    chk("sw E2 wd",    mem_wd, 32'h0000DEAD);
    chk("sw E2 valid", 32'(resp_valid), 32'd0);
    tick();
    chk("sw E3 valid", 32'(resp_valid), 32'd1);
    chk("sw E3 rdata", resp_rdata, 32'h0);
    chk("sw E3 we",    32'(mem_we), 32'd0);
    tick();
    chk("sw mem word0", mem[3], 32'hBEEF3344);
    chk("sw mem word1", mem[4], 32'h5566DEAD);

    // LW split reads the stored word back
    issue(1'b0, 3'b010, 32'h0E, 32'h0);
    tick();
    chk("lw split E2 valid", 32'(resp_valid), 32'd0);
    tick();
    chk("lw split E3 valid", 32'(resp_valid), 32'd1);
    chk("lw split rdata",    resp_rdata, 32'hDEADBEEF);
    tick();

    // LH wrapping past the top of the address space
    poke(6'd63, 32'h7F000000);
    poke(6'd0,  32'h000000C5);
    issue(1'b0, 3'b001, 32'hFFFFFFFF, 32'h0);
    chk("lh wrap E1 addr", mem_addr, 32'hFFFFFFFC);
    chk("lh wrap E1 be",   32'(mem_be), 32'h8);
    tick();
    chk("lh wrap E2 addr", mem_addr, 32'h00000000);
    chk("lh wrap E2 be",   32'(mem_be), 32'h1);
    tick();
    chk("lh wrap valid", 32'(resp_valid), 32'd1);
    chk("lh wrap rdata", resp_rdata, 32'hFFFFC57F);
    tick();

    // Illegal funct3: load 011, store 100
    issue(1'b0, 3'b011, 32'h10, 32'h0);
    chk("ill ld valid", 32'(resp_valid), 32'd1);
    chk("ill ld err",   32'(resp_err), 32'd1);
    chk("ill ld rdata", resp_rdata, 32'h0);
    chk("ill ld we",    32'(mem_we), 32'd0);
    chk("ill ld be",    32'(mem_be), 32'd0);
    tick();
    chk("ill ld E2 valid", 32'(resp_valid), 32'd0);
    chk("ill ld E2 ready", 32'(req_ready), 32'd1);
    issue(1'b1, 3'b100, 32'h10, 32'h12345678);
    chk("ill st err", 32'(resp_err), 32'd1);
    chk("ill st we",  32'(mem_we), 32'd0);
    tick();

    // Reset during the second half of a split store
    poke(6'd3, 32'h11111111);
    poke(6'd4, 32'h12345678);
    issue(1'b1, 3'b010, 32'h0E, 32'hCAFEF00D);
    tick();
    chk("rst mid ACC1 addr", mem_addr, 32'h10);
    rst_n = 1'b0;
    #1;
    chk("rst mid we",    32'(mem_we), 32'd0);
    chk("rst mid be",    32'(mem_be), 32'd0);
    chk("rst mid addr",  mem_addr, 32'h0);
    chk("rst mid wd",    mem_wd, 32'h0);
    chk("rst mid valid", 32'(resp_valid), 32'd0);
    chk("rst mid rdata", resp_rdata, 32'h0);
    tick();
    chk("rst hold valid a", 32'(resp_valid), 32'd0);
    tick();
    chk("rst hold valid b", 32'(resp_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst rel valid", 32'(resp_valid), 32'd0);
    chk("rst rel ready", 32'(req_ready), 32'd1);
    chk("rst first half", mem[3], 32'hF00D1111);
    chk("rst second half", mem[4], 32'h12345678);
    issue(1'b0, 3'b010, 32'h10, 32'h0);
    tick();
    chk("post rst valid", 32'(resp_valid), 32'd1);
    chk("post rst rdata", resp_rdata, 32'h12345678);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
